// File: rtl/pwm_bank.sv
// pwm_bank: NCH-channel PWM generator sharing one period counter.
//
// Each channel drives its output high while rise <= cnt < fall. Period and
// compare values are written into shadow registers and only take effect
// (active registers) at the counter wrap, or continuously while en=0, so a
// running waveform never glitches mid-period.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rstn       - asynchronous active-low reset
//   en         - counter run enable
//   wr_en      - channel compare write strobe
//   wr_ch      - channel index for wr_en (indices >= NCH are ignored)
//   wr_rise    - rise compare value for the written channel
//   wr_fall    - fall compare value for the written channel
//   pr_we      - period write strobe
//   pr_val     - new period value (period is pr_val+1 cycles)
//   out        - registered PWM outputs, one bit per channel
//   period_end - one-cycle pulse after each counter wrap
module pwm_bank #(
   parameter int unsigned CW      = 32,
   parameter int unsigned NCH     = 4,
   parameter int unsigned PER_RST = 50
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            en,
   input  logic            wr_en,
   input  logic [3:0]      wr_ch,
   input  logic [CW-1:0]   wr_rise,
   input  logic [CW-1:0]   wr_fall,
   input  logic            pr_we,
   input  logic [CW-1:0]   pr_val,
   output logic [NCH-1:0]  out,
   output logic            period_end
);

   localparam logic [CW-1:0] PerRst = CW'(PER_RST);

   logic [CW-1:0]           r_cnt;
   logic [CW-1:0]           r_per_s;
   logic [CW-1:0]           r_per_a;
   logic [NCH-1:0][CW-1:0]  r_rise_s;
   logic [NCH-1:0][CW-1:0]  r_fall_s;
   logic [NCH-1:0][CW-1:0]  r_rise_a;
   logic [NCH-1:0][CW-1:0]  r_fall_a;
   logic [NCH-1:0]          r_out;
   logic                    r_pend;

   logic                    w_wrap;
   logic                    w_commit;
   logic [CW-1:0]           w_cnt_d;
   logic [NCH-1:0]          w_out_d;

   // Wrap only while running; while stopped the actives track the shadows
   // every cycle so a freshly enabled counter starts with current settings.
   assign w_wrap   = en && (r_cnt == r_per_a);
   assign w_commit = !en || w_wrap;

   always_comb begin
      w_cnt_d = r_cnt;
      if (!en || w_wrap) begin
         w_cnt_d = '0;
      end else begin
         w_cnt_d = r_cnt + CW'(1);
      end
   end

   always_comb begin
      w_out_d = '0;
      for (int i = 0; i < NCH; i++) begin
         w_out_d[i] = en && (r_cnt >= r_rise_a[i]) && (r_cnt < r_fall_a[i]);
      end
   end

   // Counter and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt  <= '0;
         r_out  <= '0;
         r_pend <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_d;
         r_out  <= w_out_d;
         r_pend <= w_wrap;
      end
   end

   // Shadow registers. A write coinciding with a wrap lands here after the
   // actives have sampled the old shadow, so it commits at the next wrap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_per_s  <= PerRst;
         r_rise_s <= '0;
         r_fall_s <= '0;
      end else begin
         if (pr_we) begin
            r_per_s <= pr_val;
         end
         for (int i = 0; i < NCH; i++) begin
            if (wr_en && (wr_ch == 4'(i))) begin
               r_rise_s[i] <= wr_rise;
               r_fall_s[i] <= wr_fall;
            end
         end
      end
   end

   // Active registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_per_a  <= PerRst;
         r_rise_a <= '0;
         r_fall_a <= '0;
      end else if (w_commit) begin
         r_per_a  <= r_per_s;
         r_rise_a <= r_rise_s;
         r_fall_a <= r_fall_s;
      end
   end

   assign out        = r_out;
   assign period_end = r_pend;

endmodule
